// File: rtl/uart_rx_frame_assembler.sv
// uart_rx_frame_assembler
//   Sits behind the RX bit sampler. Collects start + DATA_BITS data bits
//   (LSB first) + optional parity + stop into one character, checks parity,
//   stop bit and break, and offers the result through a single-entry
//   valid/ready holding register with overrun detection.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   PARITY_EN   1 = one parity bit follows the data bits
//   PARITY_ODD  1 = odd parity, 0 = even parity
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_detected  1-cycle pulse: start bit seen by the sampler
//   bit_valid       1-cycle pulse: bit_sample holds a new mid-bit sample
//   bit_sample      sampled line value
//   rx_ready        consumer accepts rx_data when rx_valid=1
//   rx_data         received character, unused upper bits are 0
//   rx_valid        character and flags valid, held until accepted
//   parity_err      parity mismatch for the held character
//   frame_err       stop bit sampled 0 for the held character
//   break_det       data, parity (if enabled) and stop all 0
//   overrun_err     1-cycle pulse: completed frame dropped, register full
//   frame_done      1-cycle pulse: stop bit consumed
//   busy            FSM not idle
module uart_rx_frame_assembler #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_detected,
    input  logic       bit_valid,
    input  logic       bit_sample,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       overrun_err,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       PAR_EN   = (PARITY_EN != 0);
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);

    state_t     state;
    state_t     state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       parity_bit;

    logic       last_data_bit;
    logic       frame_complete;
    logic       calc_parity_err;
    logic       calc_frame_err;
    logic       calc_break;
    logic       accept;

    assign last_data_bit  = (bit_cnt == LAST_BIT);
    // The stop-bit bit_valid cycle; results become visible one clock later.
    assign frame_complete = (state == STOP) && bit_valid;
    assign accept         = rx_valid && rx_ready;
    assign busy           = (state != IDLE);

    // Evaluated in the stop-bit cycle: bit_sample is the stop bit itself.
    // Even parity errors on XOR=1, odd on XOR=0, hence the extra XOR with PAR_ODD.
    assign calc_parity_err = PAR_EN && ((^shift_reg) ^ parity_bit ^ PAR_ODD);
    assign calc_frame_err  = !bit_sample;
    assign calc_break      = (shift_reg == 8'h00) && !(PAR_EN && parity_bit) && !bit_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_detected) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_valid && last_data_bit) begin
                    state_next = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done  <= frame_complete;
            overrun_err <= frame_complete && rx_valid && !rx_ready;

            case (state)
                IDLE: begin
                    // Clearing here keeps bits from a previous frame out of
                    // the unused upper positions.
                    if (start_detected) begin
                        bit_cnt    <= '0;
                        shift_reg  <= '0;
                        parity_bit <= 1'b0;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        shift_reg[bit_cnt] <= bit_sample;
                        bit_cnt            <= last_data_bit ? 3'd0 : bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        parity_bit <= bit_sample;
                    end
                end
                default: ;
            endcase

            // Load wins over a same-cycle accept so rx_valid stays high.
            if (frame_complete && (!rx_valid || rx_ready)) begin
                rx_data    <= shift_reg;
                rx_valid   <= 1'b1;
                parity_err <= calc_parity_err;
                frame_err  <= calc_frame_err;
                break_det  <= calc_break;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
module tb_uart_rx_frame_assembler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start_v = '0;
    logic       bit_valid = 1'b0;
    logic       bit_sample = 1'b0;
    logic       rx_ready = 1'b0;

    logic [7:0] rd [4];
    logic       rv [4];
    logic       pe [4];
    logic       fe [4];
    logic       bd [4];
    logic       ov [4];
    logic       fd [4];
    logic       by [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 5N1, 3: 8O1
    uart_rx_frame_assembler #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start_detected(start_v[0]), .bit_valid(bit_valid),
        .bit_sample(bit_sample), .rx_ready(rx_ready), .rx_data(rd[0]), .rx_valid(rv[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]), .overrun_err(ov[0]),
        .frame_done(fd[0]), .busy(by[0]));
    uart_rx_frame_assembler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start_detected(start_v[1]), .bit_valid(bit_valid),
        .bit_sample(bit_sample), .rx_ready(rx_ready), .rx_data(rd[1]), .rx_valid(rv[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]), .overrun_err(ov[1]),
        .frame_done(fd[1]), .busy(by[1]));
    uart_rx_frame_assembler #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start_detected(start_v[2]), .bit_valid(bit_valid),
        .bit_sample(bit_sample), .rx_ready(rx_ready), .rx_data(rd[2]), .rx_valid(rv[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]), .overrun_err(ov[2]),
        .frame_done(fd[2]), .busy(by[2]));
    uart_rx_frame_assembler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start_detected(start_v[3]), .bit_valid(bit_valid),
        .bit_sample(bit_sample), .rx_ready(rx_ready), .rx_data(rd[3]), .rx_valid(rv[3]),
        .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bd[3]), .overrun_err(ov[3]),
        .frame_done(fd[3]), .busy(by[3]));

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_bit(input logic b);
        bit_valid  = 1'b1;
        bit_sample = b;
        cyc();
        bit_valid  = 1'b0;
        bit_sample = 1'b0;
    endtask

    task automatic pulse_start(input int sel);
        start_v[sel] = 1'b1;
        cyc();
        start_v = '0;
        cyc();
    endtask

    // Leaves the bench 1 ns after the edge that consumed the stop bit,
    // i.e. in the completion cycle.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic par,
                              input logic stop, input logic rdy_stop);
        int nb;
        nb = (sel == 2) ? 5 : 8;
        pulse_start(sel);
        for (int i = 0; i < nb; i++) begin
            pulse_bit(d[i]);
            cyc();
        end
        if (sel == 1 || sel == 3) begin
            pulse_bit(par);
            cyc();
        end
        rx_ready = rdy_stop;
        pulse_bit(stop);
    endtask

    task automatic check_frame(input string tag, input int sel, input logic [7:0] d,
                               input logic p, input logic f, input logic b);
        chk({tag, " rx_valid"}, 8'(rv[sel]), 8'h01);
        chk({tag, " frame_done"}, 8'(fd[sel]), 8'h01);
        chk({tag, " rx_data"}, rd[sel], d);
        chk({tag, " parity_err"}, 8'(pe[sel]), 8'(p));
        chk({tag, " frame_err"}, 8'(fe[sel]), 8'(f));
        chk({tag, " break_det"}, 8'(bd[sel]), 8'(b));
        chk({tag, " overrun_err"}, 8'(ov[sel]), 8'h00);
        chk({tag, " busy"}, 8'(by[sel]), 8'h00);
    endtask

    initial begin
        //           sel data   par   stop  exp    pe    fe    bd
        vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{2, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2, 8'h15, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3, 8'h03, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};

        // Reset state
        cyc();
        cyc();
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("reset%0d rx_valid", s), 8'(rv[s]), 8'h00);
            chk($sformatf("reset%0d rx_data", s), rd[s], 8'h00);
            chk($sformatf("reset%0d busy", s), 8'(by[s]), 8'h00);
            chk($sformatf("reset%0d frame_done", s), 8'(fd[s]), 8'h00);
            chk($sformatf("reset%0d flags", s), {4'h0, pe[s], fe[s], bd[s], ov[s]}, 8'h00);
        end
        rst_n = 1'b1;
        cyc();

        // Table-driven frames, consumer always ready
        rx_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            send_frame(vecs[v].sel, vecs[v].data, vecs[v].par, vecs[v].stop, 1'b1);
            check_frame($sformatf("vec%0d", v), vecs[v].sel, vecs[v].exp_data,
                        vecs[v].exp_pe, vecs[v].exp_fe, vecs[v].exp_bd);
            cyc();
            chk($sformatf("vec%0d rx_valid_after", v), 8'(rv[vecs[v].sel]), 8'h00);
            chk($sformatf("vec%0d frame_done_after", v), 8'(fd[vecs[v].sel]), 8'h00);
            cyc();
        end

        // Overrun: 0x11 held, 0x22 dropped
        rx_ready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
        check_frame("ovr first", 0, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc();
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
        chk("ovr overrun_err", 8'(ov[0]), 8'h01);
        chk("ovr frame_done", 8'(fd[0]), 8'h01);
        chk("ovr rx_data", rd[0], 8'h11);
        chk("ovr rx_valid", 8'(rv[0]), 8'h01);
        cyc();
        chk("ovr overrun_once", 8'(ov[0]), 8'h00);
        chk("ovr rx_data_held", rd[0], 8'h11);
        rx_ready = 1'b1;
        cyc();
        chk("ovr accepted rx_valid", 8'(rv[0]), 8'h00);
        cyc();

        // Accept and load in the same cycle
        rx_ready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
        check_frame("swap first", 0, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc();
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        check_frame("swap second", 0, 8'h22, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("swap drained", 8'(rv[0]), 8'h00);
        cyc();

        // Start mid-frame ignored; start with bit_valid in IDLE takes only the start
        start_v[0] = 1'b1;
        bit_valid  = 1'b1;
        bit_sample = 1'b1;
        cyc();
        start_v = '0;
        bit_valid = 1'b0;
        bit_sample = 1'b0;
        chk("start busy", 8'(by[0]), 8'h01);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                start_v[0] = 1'b1;
                cyc();
                start_v = '0;
            end
            pulse_bit(i[0]);
            cyc();
        end
        pulse_bit(1'b1);
        check_frame("restart", 0, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc();

        // Reset mid-frame on the 5-bit instance
        pulse_start(2);
        for (int i = 0; i < 4; i++) begin
            pulse_bit(1'b1);
            cyc();
        end
        rst_n = 1'b0;
        #2;
        chk("midrst busy", 8'(by[2]), 8'h00);
        chk("midrst rx_valid", 8'(rv[2]), 8'h00);
        cyc();
        rst_n = 1'b1;
        cyc();
        send_frame(2, 8'h1F, 1'b0, 1'b1, 1'b1);
        check_frame("midrst frame", 2, 8'h1F, 1'b0, 1'b0, 1'b0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
